// File: rtl/conv_frame_seq.sv
// conv_frame_seq
//   Frame sequencer placed in front of conv_cntrl. It checks the SOF/EOL
//   framing of an AXI-Stream-like video input against a configured frame size,
//   forwards well-formed pixels with zero latency, and after the final pixel
//   of a frame injects 2*W+4 flush beats (zero data) so the downstream line
//   buffers and window pipeline drain.
//
// Ports
//   clk, arst_n                  clock, asynchronous active-low reset
//   cfg_width_i, cfg_height_i    frame size W x H, sampled at start of frame
//   s_tvalid_i/s_tdata_i/
//   s_tuser_i/s_tlast_i          upstream stream (tuser = SOF, tlast = EOL)
//   s_tready_o                   upstream ready
//   m_tvalid_o/m_tdata_o/
//   m_tuser_o/m_tlast_o          downstream stream toward conv_cntrl
//   m_tflush_o                   marks a sequencer-generated flush beat
//   m_tready_i                   downstream ready
//   busy_o                       frame or flush in progress
//   frame_done_o                 1-cycle pulse after the last flush beat
//   err_o                        1-cycle pulse after a framing error
module conv_frame_seq #(
    parameter int PIXEL_W = 8,
    parameter int DIM_W   = 12
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic [DIM_W-1:0]   cfg_width_i,
    input  logic [DIM_W-1:0]   cfg_height_i,
    input  logic               s_tvalid_i,
    input  logic [PIXEL_W-1:0] s_tdata_i,
    input  logic               s_tuser_i,
    input  logic               s_tlast_i,
    output logic               s_tready_o,
    output logic               m_tvalid_o,
    output logic [PIXEL_W-1:0] m_tdata_o,
    output logic               m_tuser_o,
    output logic               m_tlast_o,
    output logic               m_tflush_o,
    input  logic               m_tready_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               err_o
);

    localparam int CW = DIM_W + 1;
    // 2*W+4 needs one more bit than the position counters.
    localparam int FW = DIM_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DROP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] wid_q, wid_d;
    logic [CW-1:0] hgt_q, hgt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic          s_xfer;
    logic          col_last;
    logic          row_last;
    logic          sof_pos;
    logic          beat_bad;
    logic [FW-1:0] w_ext;
    logic [FW-1:0] fl_eol0;
    logic [FW-1:0] fl_eol1;
    logic [FW-1:0] fl_end;

    assign s_xfer   = s_tvalid_i & m_tready_i;
    assign col_last = (col_q == wid_q - CW'(1));
    assign row_last = (row_q == hgt_q - CW'(1));
    assign sof_pos  = (col_q == '0) && (row_q == '0);
    // SOF is only legal at the frame origin; EOL must coincide with the last column.
    assign beat_bad = (s_tuser_i & ~sof_pos) | (s_tlast_i != col_last);

    // Flush EOL positions are W-1 and 2W-1 (index mod W = W-1 within the first 2W beats).
    assign w_ext   = FW'(wid_q);
    assign fl_eol0 = w_ext - FW'(1);
    assign fl_eol1 = (w_ext << 1) - FW'(1);
    assign fl_end  = (w_ext << 1) + FW'(3);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            wid_q   <= '0;
            hgt_q   <= '0;
            fcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            wid_q   <= wid_d;
            hgt_q   <= hgt_d;
            fcnt_q  <= fcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        wid_d   = wid_q;
        hgt_d   = hgt_q;
        fcnt_d  = fcnt_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The SOF beat is pixel (0,0), so the frame starts at column 1.
                if (s_xfer && s_tuser_i) begin
                    state_d = S_ACTIVE;
                    col_d   = CW'(1);
                    row_d   = '0;
                    wid_d   = CW'(cfg_width_i);
                    hgt_d   = CW'(cfg_height_i);
                end
            end
            S_ACTIVE: begin
                if (s_xfer) begin
                    if (beat_bad) begin
                        state_d = S_DROP;
                        err_d   = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                    end else if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            fcnt_d  = '0;
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + CW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (m_tready_i) begin
                    if (fcnt_q == fl_end) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            S_DROP: begin
                // The SOF is left pending on the input and taken by IDLE.
                if (s_tvalid_i && s_tuser_i && m_tready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_tready_o = m_tready_i;
        m_tvalid_o = 1'b0;
        m_tdata_o  = s_tdata_i;
        m_tuser_o  = s_tuser_i;
        m_tlast_o  = s_tlast_i;
        m_tflush_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by reset so no beat leaks out while the block is held.
                m_tvalid_o = s_tvalid_i & s_tuser_i & arst_n;
            end
            S_ACTIVE: begin
                m_tvalid_o = s_tvalid_i & ~beat_bad;
            end
            S_FLUSH: begin
                s_tready_o = 1'b0;
                m_tvalid_o = 1'b1;
                m_tdata_o  = '0;
                m_tuser_o  = (fcnt_q == '0);
                m_tlast_o  = (fcnt_q == fl_eol0) | (fcnt_q == fl_eol1);
                m_tflush_o = 1'b1;
            end
            S_DROP: begin
                s_tready_o = ~(s_tvalid_i & s_tuser_i);
            end
            default: ;
        endcase
    end

    assign busy_o       = (state_q == S_ACTIVE) || (state_q == S_FLUSH);
    assign frame_done_o = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_conv_frame_seq.sv
// tb_conv_frame_seq
//   Directed bench for conv_frame_seq. A queue holds the beats the
//   downstream side must see, built from the frame rules (pixels with SOF
//   at the origin and EOL at the last column, then 2*W+4 zero flush beats).
//   A negedge process compares every downstream transfer, the done/error
//   pulses, output hold during stalls and upstream ready during flush.
module tb_conv_frame_seq;

    localparam int PW = 8;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [DW-1:0] cfg_width_i = 12'd4;
    logic [DW-1:0] cfg_height_i = 12'd3;
    logic          s_tvalid_i = 1'b0;
    logic [PW-1:0] s_tdata_i = '0;
    logic          s_tuser_i = 1'b0;
    logic          s_tlast_i = 1'b0;
    logic          s_tready_o;
    logic          m_tvalid_o;
    logic [PW-1:0] m_tdata_o;
    logic          m_tuser_o;
    logic          m_tlast_o;
    logic          m_tflush_o;
    logic          m_tready_i = 1'b1;
    logic          busy_o;
    logic          frame_done_o;
    logic          err_o;

    conv_frame_seq #(.PIXEL_W(PW), .DIM_W(DW)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .cfg_width_i (cfg_width_i),
        .cfg_height_i(cfg_height_i),
        .s_tvalid_i  (s_tvalid_i),
        .s_tdata_i   (s_tdata_i),
        .s_tuser_i   (s_tuser_i),
        .s_tlast_i   (s_tlast_i),
        .s_tready_o  (s_tready_o),
        .m_tvalid_o  (m_tvalid_o),
        .m_tdata_o   (m_tdata_o),
        .m_tuser_o   (m_tuser_o),
        .m_tlast_o   (m_tlast_o),
        .m_tflush_o  (m_tflush_o),
        .m_tready_i  (m_tready_i),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] d;
        logic          u;
        logic          l;
        logic          f;
        logic          fin;
    } beat_t;

    beat_t exp_q[$];

    int   total = 0;
    int   bad = 0;
    int   ndone = 0;
    int   nerr = 0;
    logic done_pend = 1'b0;
    logic err_pend = 1'b0;
    logic s_bad = 1'b0;
    logic tog = 1'b0;
    logic prev_stall = 1'b0;
    logic [11:0] prev_out = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected downstream beats for one frame; a bad pixel at (er,ec) ends the
    // frame there with no flush.
    function automatic void push_frame(int w, int h, int base, int er, int ec);
        beat_t b;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (r == er && c == ec) return;
                b.d = PW'(base + r * 16 + c);
                b.u = (r == 0 && c == 0);
                b.l = (c == w - 1);
                b.f = 1'b0;
                b.fin = 1'b0;
                exp_q.push_back(b);
            end
        end
        for (int i = 0; i < 2 * w + 4; i++) begin
            b.d = '0;
            b.u = (i == 0);
            b.l = (i < 2 * w) && (i % w == w - 1);
            b.f = 1'b1;
            b.fin = (i == 2 * w + 3);
            exp_q.push_back(b);
        end
    endfunction

    // Downstream ready toggles every cycle while tog is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tog) m_tready_i = ~m_tready_i;
        end
    end

    always @(negedge clk) begin
        logic [11:0] cur;
        beat_t e;
        cur = {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o, m_tflush_o};
        if (!arst_n) begin
            done_pend = 1'b0;
            err_pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done_o), 32'(done_pend));
            chk("err", 32'(err_o), 32'(err_pend));
            if (frame_done_o) ndone++;
            if (err_o) nerr++;
            done_pend = 1'b0;
            err_pend = 1'b0;
            if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
            if (m_tvalid_o && m_tready_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({m_tdata_o, m_tuser_o, m_tlast_o, m_tflush_o}),
                        32'({e.d, e.u, e.l, e.f}));
                    if (e.fin) done_pend = 1'b1;
                end
            end
            if (s_tvalid_i && s_tready_o && s_bad) err_pend = 1'b1;
            if (m_tvalid_o && m_tflush_o) chk("flush_sready", 32'(s_tready_o), 32'd0);
            prev_stall = m_tvalid_o & ~m_tready_i;
            prev_out = cur;
        end
    end

    task automatic send_beat(input logic [PW-1:0] d, input logic u, input logic l, input logic b);
        logic acc;
        s_tvalid_i = 1'b1;
        s_tdata_i = d;
        s_tuser_i = u;
        s_tlast_i = l;
        s_bad = b;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (s_tready_o) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_beat_timeout: got no ready want ready");
        end
    endtask

    task automatic send_frame(input int w, input int h, input int base, input int er,
                              input int ec, input int new_w, input logic gap);
        logic b;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                b = (r == er && c == ec);
                send_beat(PW'(base + r * 16 + c), (r == 0 && c == 0), (c == w - 1) | b, b);
                if (r == 0 && c == 0 && new_w != 0) cfg_width_i = DW'(new_w);
                if (gap && c == 1) begin
                    s_tvalid_i = 1'b0;
                    s_bad = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_tvalid_i = 1'b0;
        s_tuser_i = 1'b0;
        s_tlast_i = 1'b0;
        s_bad = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 3000 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: got %0d beats left want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        int e0;
        logic [15:0] lmask;
        logic [15:0] umask;

        // Reset values
        #12;
        chk("rst_mvalid", 32'(m_tvalid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(frame_done_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_sready_hi", 32'(s_tready_o), 32'd1);
        m_tready_i = 1'b0;
        #1;
        chk("rst_sready_lo", 32'(s_tready_o), 32'd0);
        m_tready_i = 1'b1;
        @(posedge clk);
        #1;
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // W=4,H=3 clean frame; model pinned to literal flush layout
        push_frame(4, 3, 8'h10, -1, -1);
        chk("model_size", 32'(exp_q.size()), 32'd24);
        lmask = '0;
        umask = '0;
        for (int i = 0; i < 12; i++) begin
            lmask[i] = exp_q[12 + i].l;
            umask[i] = exp_q[12 + i].u;
        end
        chk("model_tlast", 32'(lmask), 32'h088);
        chk("model_tuser", 32'(umask), 32'h001);
        d0 = ndone;
        send_frame(4, 3, 8'h10, -1, -1, 0, 1'b0);
        wait_drain("clean");
        chk("done_clean", 32'(ndone - d0), 32'd1);
        chk("busy_after", 32'(busy_o), 32'd0);

        // Same frame with downstream ready toggling
        push_frame(4, 3, 8'h10, -1, -1);
        d0 = ndone;
        tog = 1'b1;
        send_frame(4, 3, 8'h10, -1, -1, 0, 1'b0);
        wait_drain("toggle");
        tog = 1'b0;
        m_tready_i = 1'b1;
        chk("done_toggle", 32'(ndone - d0), 32'd1);

        // Source gaps inside the frame
        push_frame(4, 3, 8'h20, -1, -1);
        d0 = ndone;
        send_frame(4, 3, 8'h20, -1, -1, 0, 1'b1);
        wait_drain("gap");
        chk("done_gap", 32'(ndone - d0), 32'd1);

        // EOL on col 2 of row 1, then a clean frame
        e0 = nerr;
        d0 = ndone;
        push_frame(4, 3, 8'h40, 1, 2);
        send_frame(4, 3, 8'h40, 1, 2, 0, 1'b0);
        push_frame(4, 3, 8'h50, -1, -1);
        send_frame(4, 3, 8'h50, -1, -1, 0, 1'b0);
        wait_drain("err");
        chk("err_count", 32'(nerr - e0), 32'd1);
        chk("done_after_err", 32'(ndone - d0), 32'd1);

        // Non-SOF beats in IDLE are discarded silently
        e0 = nerr;
        d0 = ndone;
        for (int i = 0; i < 3; i++) send_beat(PW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        s_tvalid_i = 1'b0;
        push_frame(4, 3, 8'h60, -1, -1);
        send_frame(4, 3, 8'h60, -1, -1, 0, 1'b0);
        wait_drain("junk");
        chk("junk_err", 32'(nerr - e0), 32'd0);
        chk("junk_done", 32'(ndone - d0), 32'd1);

        // Width change mid-frame takes effect on the next frame only
        d0 = ndone;
        push_frame(4, 3, 8'h70, -1, -1);
        send_frame(4, 3, 8'h70, -1, -1, 6, 1'b0);
        wait_drain("cfg_old");
        push_frame(6, 3, 8'h80, -1, -1);
        chk("model_size6", 32'(exp_q.size()), 32'd34);
        lmask = '0;
        for (int i = 0; i < 16; i++) lmask[i] = exp_q[18 + i].l;
        chk("model_tlast6", 32'(lmask), 32'h0820);
        send_frame(6, 3, 8'h80, -1, -1, 0, 1'b0);
        wait_drain("cfg_new");
        chk("done_cfg", 32'(ndone - d0), 32'd2);
        cfg_width_i = 12'd4;

        // Reset while flush beat 5 is on the output
        push_frame(4, 3, 8'h90, -1, -1);
        send_frame(4, 3, 8'h90, -1, -1, 0, 1'b0);
        for (int k = 0; k < 200 && exp_q.size() > 7; k++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("flush_busy", 32'(busy_o), 32'd1);
        chk("flush_marker", 32'(m_tflush_o), 32'd1);
        d0 = ndone;
        e0 = nerr;
        arst_n = 1'b0;
        #1;
        chk("midrst_mvalid", 32'(m_tvalid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_sready", 32'(s_tready_o), 32'(m_tready_i));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_nodone", 32'(ndone - d0), 32'd0);
        push_frame(4, 3, 8'hB0, -1, -1);
        send_frame(4, 3, 8'hB0, -1, -1, 0, 1'b0);
        wait_drain("post_rst");
        chk("done_post_rst", 32'(ndone - d0), 32'd1);
        chk("err_post_rst", 32'(nerr - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_frame_seq.md
CONV_FRAME_SEQ -- requirements
Module: conv_frame_seq

Interface
REQ-001 SHALL have parameter PIXEL_W, default 8: pixel data width, equal to conv_pkg::PIXEL_W.
REQ-002 SHALL have parameter DIM_W, default 12: width of the frame-dimension configuration and counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port cfg_width_i, input, DIM_W bits: pixels per line W, legal range 3..2^DIM_W-1.
REQ-006 SHALL have port cfg_height_i, input, DIM_W bits: lines per frame H, legal range 3..2^DIM_W-1.
REQ-007 SHALL have ports s_tvalid_i/s_tdata_i/s_tuser_i/s_tlast_i, input, 1/PIXEL_W/1/1 bits: upstream stream; tuser = SOF, tlast = EOL.
REQ-008 SHALL have port s_tready_o, output, 1 bit: upstream ready.
REQ-009 SHALL have ports m_tvalid_o/m_tdata_o/m_tuser_o/m_tlast_o, output, 1/PIXEL_W/1/1 bits: stream toward conv_cntrl.
REQ-010 SHALL have port m_tflush_o, output, 1 bit: marks a sequencer-generated flush pixel.
REQ-011 SHALL have port m_tready_i, input, 1 bit: downstream ready.
REQ-012 SHALL have ports busy_o, frame_done_o, err_o, output, 1 bit each: frame in progress; 1-cycle pulse at end of flush; 1-cycle pulse on protocol error.

Function
REQ-013 SHALL implement FSM states IDLE, ACTIVE, FLUSH, DROP; transfer = valid & ready on the relevant side.
REQ-014 IDLE: s_tready_o = m_tready_i; forward a beat only if s_tuser_i=1, then enter ACTIVE with col=1 (col=0, row=1 if W=1 is illegal, not checked); beats with s_tuser_i=0 consumed and discarded, no error.
REQ-015 ACTIVE: m_t* = s_t* combinationally (zero latency), m_tflush_o=0, s_tready_o = m_tready_i; col counts 0..W-1, row counts 0..H-1 on each transfer.
REQ-016 ACTIVE error: transfer with s_tuser_i=1 when not (col=0,row=0), or s_tlast_i != (col=W-1) -> err_o pulse the following cycle, beat not forwarded (m_tvalid_o=0), enter DROP.
REQ-017 ACTIVE: transfer at col=W-1,row=H-1 -> enter FLUSH, flush counter cleared.
REQ-018 FLUSH: s_tready_o=0; m_tvalid_o=1, m_tdata_o=0, m_tflush_o=1; F = 2*W+4 flush beats, counter advances only when m_tready_i=1.
REQ-019 FLUSH: m_tuser_o=1 on flush beat 0 only; m_tlast_o=1 on flush beats with index mod W = W-1 and index < 2*W; last 4 beats carry no tlast.
REQ-020 FLUSH: transfer of beat F-1 -> frame_done_o pulse next cycle, enter IDLE.
REQ-021 DROP: s_tready_o=1, m_tvalid_o=0; discard beats until a beat with s_tuser_i=1 arrives, which is not consumed (s_tready_o=0 that cycle) and state moves to IDLE.
REQ-022 busy_o SHALL be 1 in ACTIVE and FLUSH, 0 otherwise.
REQ-023 cfg_width_i/cfg_height_i SHALL be sampled into shadow registers on the IDLE->ACTIVE transfer; changes mid-frame have no effect.
REQ-024 Counters SHALL be DIM_W+1 bits internally; 2*W+4 computed without overflow.
REQ-025 m_tready_i=0 SHALL freeze all counters and state; m_t* outputs stay stable while m_tvalid_o=1.
REQ-026 A gap in s_tvalid_i during ACTIVE SHALL not be an error; m_tvalid_o follows it.

Reset
REQ-027 arst_n low SHALL force state IDLE, counters and shadow registers 0, busy_o=0, frame_done_o=0, err_o=0, m_tvalid_o=0, s_tready_o=m_tready_i.
REQ-028 Reset mid-frame or mid-flush SHALL abandon the frame; no frame_done_o or err_o emitted.

Verification
REQ-029 W=4,H=3, continuous stream, m_tready_i=1 -> 12 beats forwarded unchanged, then 12 flush beats: tuser at beat 0, tlast at beats 3 and 7; frame_done_o pulse one cycle after flush beat 11.
REQ-030 Same frame, m_tready_i toggling 1,0 every cycle -> identical output beat sequence; counters hold on stalled cycles; s_tready_o=0 throughout FLUSH.
REQ-031 W=4,H=3, tlast asserted on pixel col 2 of row 1 -> err_o pulse, beat dropped, DROP discards until next SOF; next frame processes cleanly with frame_done_o.
REQ-032 Three beats with s_tuser_i=0 in IDLE then a valid frame -> first three beats discarded, no err_o, frame output correct.
REQ-033 cfg_width_i changed 4->6 mid-frame -> current frame and flush use W=4 (12 flush beats); next frame uses W=6 (16 flush beats).
REQ-034 arst_n pulsed during FLUSH beat 5 -> outputs at reset values, no frame_done_o; a subsequent frame completes normally.
